// File: rtl/fade_sched.sv
`default_nettype none
// ============================================================================
// Module   : fade_sched
// Brief    : Frame scheduler for the fader -> IFFT chain. Sends the IFFT
//            config word, issues periodic start/t_index to the fader, tracks
//            each frame through fader beats and IFFT tlast, and flags
//            overruns and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module fade_sched #(
    parameter int NCHAN    = 32,
    parameter int PERIOD_W = 10,
    parameter int TIDX_W   = 25,
    parameter int TIMEOUT  = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [15:0]         cfg_data,
    input  logic                cfg_update,
    output logic                start,
    output logic [TIDX_W-1:0]   t_index,
    input  logic                fader_dv,
    output logic [15:0]         cfg_tdata,
    output logic                cfg_tvalid,
    input  logic                cfg_tready,
    input  logic                ifft_tvalid,
    input  logic                ifft_tlast,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic                err_overrun,
    output logic                err_timeout
);

    localparam int c_BEAT_W = $clog2(NCHAN + 1);
    localparam int c_TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_CONFIG   = 2'd0,
        ST_IDLE     = 2'd1,
        ST_COLLECT  = 2'd2,
        ST_WAIT_OUT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PERIOD_W-1:0]   r_pcnt;
    logic [PERIOD_W-1:0]   w_period_m1;
    logic                  w_expire;
    logic                  w_pend;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic                  r_cfg_pending;
    logic                  r_cfg_tvalid;
    logic [15:0]           r_cfg_tdata;
    logic                  r_start;
    logic [TIDX_W-1:0]     r_t_index;
    logic                  r_frame_done;
    logic [15:0]           r_frame_count;
    logic                  r_err_overrun;
    logic                  r_err_timeout;
    logic                  r_busy;

    logic                  w_start_next;
    logic                  w_done_next;
    logic                  w_overrun_set;
    logic                  w_timeout_set;
    logic                  w_cfg_load;
    logic                  w_clr_cnt;
    logic                  w_tout_hit;

    // A zero period behaves like a period of one cycle.
    assign w_period_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign w_expire    = enable && (r_pcnt == '0);
    assign w_pend      = r_cfg_pending || cfg_update;
    assign w_tout_hit  = (r_tcnt == c_TCNT_W'(TIMEOUT - 1));

    // Period down-counter: held at its reload value while disabled.
    always_ff @(posedge clk) begin
        if (reset || !enable || r_pcnt == '0) begin
            r_pcnt <= w_period_m1;
        end else begin
            r_pcnt <= r_pcnt - PERIOD_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CONFIG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and event decode; any expiry outside a clean IDLE is an overrun.
    always_comb begin
        w_state_next  = r_state;
        w_start_next  = 1'b0;
        w_done_next   = 1'b0;
        w_overrun_set = 1'b0;
        w_timeout_set = 1'b0;
        w_cfg_load    = 1'b0;
        w_clr_cnt     = 1'b0;
        case (r_state)
            ST_CONFIG: begin
                w_overrun_set = w_expire;
                if (r_cfg_tvalid && cfg_tready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_pend) begin
                    w_state_next  = ST_CONFIG;
                    w_cfg_load    = 1'b1;
                    w_overrun_set = w_expire;
                end else if (w_expire) begin
                    w_state_next = ST_COLLECT;
                    w_start_next = 1'b1;
                    w_clr_cnt    = 1'b1;
                end
            end
            ST_COLLECT: begin
                w_overrun_set = w_expire;
                if (w_tout_hit) begin
                    w_timeout_set = 1'b1;
                    w_state_next  = ST_IDLE;
                end else if (fader_dv && r_beat == c_BEAT_W'(NCHAN - 1)) begin
                    w_state_next = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                w_overrun_set = w_expire;
                if (ifft_tvalid && ifft_tlast) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_tout_hit) begin
                    w_timeout_set = 1'b1;
                    w_state_next  = ST_IDLE;
                end
            end
            default: w_state_next = ST_CONFIG;
        endcase
    end

    // Datapath registers: config word, counters, pulses and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_tdata   <= cfg_data;
            r_cfg_tvalid  <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_start       <= 1'b0;
            r_t_index     <= '0;
            r_beat        <= '0;
            r_tcnt        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cfg_tvalid <= (w_state_next == ST_CONFIG);
            r_busy       <= (w_state_next != ST_IDLE);
            if (w_cfg_load) begin
                r_cfg_tdata <= cfg_data;
            end
            if (w_cfg_load) begin
                r_cfg_pending <= 1'b0;
            end else if (cfg_update) begin
                r_cfg_pending <= 1'b1;
            end
            r_start <= w_start_next;
            if (w_start_next) begin
                r_t_index <= r_t_index + TIDX_W'(1);
            end
            if (w_clr_cnt) begin
                r_beat <= '0;
                r_tcnt <= '0;
            end else begin
                if (r_state == ST_COLLECT && fader_dv) begin
                    r_beat <= r_beat + c_BEAT_W'(1);
                end
                if (r_state == ST_COLLECT || r_state == ST_WAIT_OUT) begin
                    r_tcnt <= r_tcnt + c_TCNT_W'(1);
                end
            end
            r_frame_done <= w_done_next;
            if (w_done_next) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_overrun_set) begin
                r_err_overrun <= 1'b1;
            end
            if (w_timeout_set) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign start       = r_start;
    assign t_index     = r_t_index;
    assign cfg_tdata   = r_cfg_tdata;
    assign cfg_tvalid  = r_cfg_tvalid;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire
